// File: rtl/gb_pkg.sv
// Shared Game Boy bus constants and the OAM DMA state encoding.
package gb_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam int          OAM_LEN      = 160;
  localparam logic [7:0]  ECHO_MASK    = 8'hDF;

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER
  } dma_state_t;

  // Sources in the echo region (E0-FF) alias onto WRAM (C0-DF).
  function automatic logic [7:0] echo_map(input logic [7:0] src);
    return (src >= 8'hE0) ? (src & ECHO_MASK) : src;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies LEN bytes from {FF46,8'h00} into OAM, one byte per cycle.
// Build option: define OAM_DMA_READBACK_EN to make FF46 readable; otherwise it reads 8'hFF.
module oam_dma
  import gb_pkg::*;
#(
  parameter int LEN = OAM_LEN
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_w,
  input  logic        cpu_write_enable,
  output logic [7:0]  cpu_data_r,
  output logic        cpu_data_active,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic        mem_active,
  input  logic [7:0]  mem_data_r,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data_w,
  output logic        oam_write_enable
);

  localparam logic [7:0] LAST = 8'(LEN - 1);

  dma_state_t  state_q, state_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  n_q, n_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        mem_active_q, mem_active_d;
  logic        busy_q, busy_d;
  logic        oam_we_q, oam_we_d;
  logic [7:0]  oam_addr_q, oam_addr_d;
  logic [7:0]  oam_data_q, oam_data_d;

  logic       trigger;
  logic [7:0] src_m;

  assign trigger         = cpu_write_enable && (cpu_addr == DMA_REG_ADDR);
  assign cpu_data_active = !cpu_write_enable && (cpu_addr == DMA_REG_ADDR);
  assign src_m           = echo_map(src_q);

`ifdef OAM_DMA_READBACK_EN
  assign cpu_data_r = src_q;
`else
  assign cpu_data_r = 8'hFF;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case; a path that leaves one unassigned infers a latch.
    state_d      = state_q;
    src_d        = src_q;
    n_d          = n_q;
    mem_addr_d   = mem_addr_q;
    mem_active_d = 1'b0;
    oam_we_d     = 1'b0;
    oam_addr_d   = oam_addr_q;
    oam_data_d   = oam_data_q;

    unique case (state_q)
      START: begin
        state_d      = XFER;
        n_d          = 8'h00;
        mem_active_d = 1'b1;
        mem_addr_d   = {src_m, 8'h00};
      end
      XFER: begin
        // Byte read this cycle is written to OAM next cycle, overlapping the next read.
        oam_we_d   = 1'b1;
        oam_addr_d = n_q;
        oam_data_d = mem_data_r;
        if (n_q == LAST) begin
          state_d = IDLE;
        end else begin
          n_d          = n_q + 8'd1;
          mem_active_d = 1'b1;
          mem_addr_d   = {src_m, n_q + 8'd1};
        end
      end
      default: ;
    endcase

    // A new trigger wins in every state and discards the old transfer's pending write.
    if (trigger) begin
      src_d        = cpu_data_w;
      state_d      = START;
      n_d          = 8'h00;
      mem_active_d = 1'b0;
      oam_we_d     = 1'b0;
    end

    busy_d = (state_d != IDLE) || oam_we_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      src_q        <= 8'hFF;
      n_q          <= 8'h00;
      mem_addr_q   <= 16'h0000;
      mem_active_q <= 1'b0;
      busy_q       <= 1'b0;
      oam_we_q     <= 1'b0;
      oam_addr_q   <= 8'h00;
      oam_data_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      n_q          <= n_d;
      mem_addr_q   <= mem_addr_d;
      mem_active_q <= mem_active_d;
      busy_q       <= busy_d;
      oam_we_q     <= oam_we_d;
      oam_addr_q   <= oam_addr_d;
      oam_data_q   <= oam_data_d;
    end
  end

  assign busy             = busy_q;
  assign mem_addr         = mem_addr_q;
  assign mem_active       = mem_active_q;
  assign oam_addr         = oam_addr_q;
  assign oam_data_w       = oam_data_q;
  assign oam_write_enable = oam_we_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: scoreboard of expected bus reads and OAM writes, checked every cycle.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_w;
  logic        cpu_write_enable;
  logic [7:0]  cpu_data_r;
  logic        cpu_data_active;
  logic        busy;
  logic [15:0] mem_addr;
  logic        mem_active;
  logic [7:0]  mem_data_r;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data_w;
  logic        oam_write_enable;

  oam_dma dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cpu_addr         (cpu_addr),
    .cpu_data_w       (cpu_data_w),
    .cpu_write_enable (cpu_write_enable),
    .cpu_data_r       (cpu_data_r),
    .cpu_data_active  (cpu_data_active),
    .busy             (busy),
    .mem_addr         (mem_addr),
    .mem_active       (mem_active),
    .mem_data_r       (mem_data_r),
    .oam_addr         (oam_addr),
    .oam_data_w       (oam_data_w),
    .oam_write_enable (oam_write_enable)
  );

  always #5 clk = ~clk;

  // Responder: drives read data on the falling edge from the address the DMA presents.
  always @(negedge clk) mem_data_r = mem_active ? (mem_addr[7:0] ^ 8'h5A) : 8'h00;

`ifdef OAM_DMA_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  typedef struct {
    logic [7:0] idx;
    logic [7:0] data;
  } oam_exp_t;

  logic [15:0] exp_addr_q[$];
  oam_exp_t    exp_oam_q[$];

  int checks   = 0;
  int errors   = 0;
  int busy_cnt = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one cycle, then compare the new cycle's bus activity against the scoreboard.
  task automatic tick();
    oam_exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cnt++;
    if (mem_active) begin
      if (exp_addr_q.size() == 0) check("mem_active_unexpected", mem_active, 1'b0);
      else check("mem_addr", mem_addr, exp_addr_q.pop_front());
    end
    if (oam_write_enable) begin
      if (exp_oam_q.size() == 0) begin
        check("oam_write_unexpected", oam_write_enable, 1'b0);
      end else begin
        e = exp_oam_q.pop_front();
        check("oam_addr", oam_addr, e.idx);
        check("oam_data_w", oam_data_w, e.data);
      end
    end
  endtask

  task automatic push_xfer(input logic [7:0] base, input int n_reads, input int n_writes);
    oam_exp_t e;
    for (int i = 0; i < n_reads; i++) exp_addr_q.push_back({base, 8'(i)});
    for (int i = 0; i < n_writes; i++) begin
      e.idx  = 8'(i);
      e.data = 8'(i) ^ 8'h5A;
      exp_oam_q.push_back(e);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr         = a;
    cpu_data_w       = d;
    cpu_write_enable = 1'b1;
    tick();
    cpu_write_enable = 1'b0;
    cpu_addr         = 16'h0000;
  endtask

  // Trigger a DMA; the tick inside cpu_write lands in the START cycle.
  task automatic start_xfer(input logic [7:0] src, input logic [7:0] base,
                            input int n_reads, input int n_writes);
    push_xfer(base, n_reads, n_writes);
    busy_cnt = 0;
    cpu_write(16'hFF46, src);
    check("start_busy", busy, 1'b1);
    check("start_mem_active", mem_active, 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && busy; i++) tick();
    check({tag, "_busy_timeout"}, busy, 1'b0);
    check({tag, "_busy_cycles"}, busy_cnt, 162);
    check({tag, "_reads_left"}, exp_addr_q.size(), 0);
    check({tag, "_writes_left"}, exp_oam_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_mem_active"}, mem_active, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 16'h0000);
    check({tag, "_oam_we"}, oam_write_enable, 1'b0);
    check({tag, "_oam_addr"}, oam_addr, 8'h00);
    check({tag, "_oam_data"}, oam_data_w, 8'h00);
    cpu_addr = 16'hFF46;
    #1;
    check({tag, "_ff46_read"}, cpu_data_r, 8'hFF);
    check({tag, "_ff46_active"}, cpu_data_active, 1'b1);
    cpu_addr = 16'h0000;
  endtask

  initial begin
    reset_n          = 1'b0;
    cpu_addr         = 16'h0000;
    cpu_data_w       = 8'h00;
    cpu_write_enable = 1'b0;
    mem_data_r       = 8'h00;

    tick();
    tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Writes to other registers must not start anything.
    cpu_write(16'hFF45, 8'hC1);
    tick();
    check("non_ff46_busy", busy, 1'b0);

    // Basic copy from C100.
    start_xfer(8'hC1, 8'hC1, 160, 160);
    wait_idle("basic");

    // Echo source E3 reads from C300.
    start_xfer(8'hE3, 8'hC3, 160, 160);
    wait_idle("echo");
`ifdef OAM_DMA_READBACK_EN
    cpu_addr = 16'hFF46;
    #1;
    check("echo_ff46_unmasked", cpu_data_r, 8'hE3);
    cpu_addr = 16'h0000;
`endif

    // Restart during the read of byte 50: byte 50 is read but never written.
    start_xfer(8'h80, 8'h80, 51, 50);
    for (int i = 0; i < 51; i++) tick();
    check("restart_reads_done", exp_addr_q.size(), 0);
    start_xfer(8'h90, 8'h90, 160, 160);
    wait_idle("restart");

    // Back-to-back: the second trigger is sampled in the first idle cycle.
    start_xfer(8'hC5, 8'hC5, 160, 160);
    wait_idle("b2b_first");
    start_xfer(8'hC6, 8'hC6, 160, 160);
    wait_idle("b2b_second");

    // Readback during a transfer; reads must not disturb it.
    start_xfer(8'h42, 8'h42, 160, 160);
    tick();
    cpu_addr = 16'hFF46;
    #1;
    check("readback_value", cpu_data_r, READBACK ? 8'h42 : 8'hFF);
    check("readback_active", cpu_data_active, 1'b1);
    cpu_addr = 16'hFF47;
    #1;
    check("other_addr_inactive", cpu_data_active, 1'b0);
    cpu_addr         = 16'hFF46;
    cpu_write_enable = 1'b1;
    #1;
    check("ff46_write_inactive", cpu_data_active, 1'b0);
    cpu_write_enable = 1'b0;
    cpu_addr         = 16'hFF46;
    for (int i = 0; i < 20; i++) tick();
    cpu_addr = 16'h0000;
    wait_idle("readback");

    // Reset during the read of byte 100: write of byte 99 lands, nothing after.
    start_xfer(8'hC1, 8'hC1, 101, 100);
    for (int i = 0; i < 101; i++) tick();
    reset_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("midreset_busy_after", busy, 1'b0);
    check("midreset_reads_left", exp_addr_q.size(), 0);
    check("midreset_writes_left", exp_oam_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
